// File: rtl/alu_issue_arb_pkg.sv
// Shared definitions for the ALU issue arbiter: warp/index widths and the
// branch ALUop and flag encodings agreed between the OC and the ALU.
package alu_issue_arb_pkg;

  localparam int unsigned WARP_ID_W    = 3;
  localparam int unsigned NUM_WARP_DEF = 8;
  localparam int unsigned GRANT_IDX_W  = 3;
  localparam int unsigned ALU_OP_W     = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_ADD  = 4'h0,
    ALU_OP_SUB  = 4'h1,
    ALU_OP_AND  = 4'h2,
    ALU_OP_OR   = 4'h3,
    ALU_OP_XOR  = 4'h4,
    ALU_OP_SLL  = 4'h5,
    ALU_OP_SRL  = 4'h6,
    ALU_OP_SLT  = 4'h7,
    ALU_OP_BEQ  = 4'h8,
    ALU_OP_BLT  = 4'h9
  } alu_op_e;

  // Per-entry issue flags carried alongside the ALU op.
  typedef struct packed {
    logic                 branch;
    logic                 reg_write;
    logic [WARP_ID_W-1:0] warp_id;
  } issue_flags_t;

  function automatic logic is_branch_op(input alu_op_e op);
    return (op == ALU_OP_BEQ) || (op == ALU_OP_BLT);
  endfunction

endpackage

// File: rtl/alu_issue_arb_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or above ptr,
// wrapping at N-1. Shared with the MEM-unit arbiter.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < int'(N); off++) begin
      k = int'(ptr) + off;
      if (k >= int'(N)) k = k - int'(N);
      for (int j = 0; j < int'(N); j++) begin
        if (!found && (k == j) && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_arb.sv
// Round-robin ALU issue arbiter with per-warp branch-pending blocking and
// CDB-busy withholding. Optional perf counters under ALU_ARB_PERF_CNT_EN.
module alu_issue_arb
  import alu_issue_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_WARP = NUM_WARP_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             Req_OC_Arb,
  input  logic [WARP_ID_W*NUM_REQ-1:0]   ReqWarpID_OC_Arb,
  input  logic [NUM_REQ-1:0]             ReqBranch_OC_Arb,
  input  logic [NUM_REQ-1:0]             ReqRegWrite_OC_Arb,
  input  logic                           CdbBusy_Arb,
  input  logic                           Br_ALU_SIMT,
  input  logic [WARP_ID_W-1:0]           WarpID_ALU_SIMT,
`ifdef ALU_ARB_PERF_CNT_EN
  output logic [31:0]                    IssueCnt_Arb,
  output logic [31:0]                    StallCnt_Arb,
`endif
  output logic [NUM_REQ-1:0]             Grant_Arb_OC,
  output logic [GRANT_IDX_W-1:0]         GrantIdx_Arb_OC,
  output logic                           Valid_OC_ALU,
  output logic [NUM_WARP-1:0]            BrPending_Arb
);

  logic [GRANT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_WARP-1:0]    br_pend_q, br_pend_d;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic [GRANT_IDX_W-1:0] pick_idx;
  logic                   grant_any;
  logic                   grant_branch;
  logic [WARP_ID_W-1:0]   grant_warp;

  // An entry is eligible unless its warp awaits a branch outcome or it
  // needs a CDB slot that is already claimed.
  always_comb begin
    logic [WARP_ID_W-1:0] w;
    logic                 blocked;
    eligible = '0;
    w        = '0;
    blocked  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w       = ReqWarpID_OC_Arb[WARP_ID_W*i +: WARP_ID_W];
      blocked = 1'b0;
      for (int j = 0; j < int'(NUM_WARP); j++) begin
        if ((w == WARP_ID_W'(j)) && br_pend_q[j]) blocked = 1'b1;
      end
      eligible[i] = Req_OC_Arb[i] && !blocked &&
                    !(ReqRegWrite_OC_Arb[i] && CdbBusy_Arb);
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (GRANT_IDX_W)
  ) u_rr_pick (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grants are suppressed while reset is asserted; the OC is reset alongside.
  assign Grant_Arb_OC    = rst ? pick_gnt : '0;
  assign GrantIdx_Arb_OC = rst ? pick_idx : '0;
  assign grant_any       = |Grant_Arb_OC;
  assign Valid_OC_ALU    = grant_any;
  assign BrPending_Arb   = br_pend_q;

  always_comb begin
    grant_branch = 1'b0;
    grant_warp   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (Grant_Arb_OC[i]) begin
        grant_branch = ReqBranch_OC_Arb[i];
        grant_warp   = ReqWarpID_OC_Arb[WARP_ID_W*i +: WARP_ID_W];
      end
    end
  end

  // Pointer advances past the winner; pending set is applied after clear
  // so a same-warp set/clear collision leaves the bit set.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    br_pend_d = br_pend_q;
    if (grant_any) begin
      if (GrantIdx_Arb_OC == GRANT_IDX_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else rr_ptr_d = GrantIdx_Arb_OC + GRANT_IDX_W'(1);
    end
    for (int j = 0; j < int'(NUM_WARP); j++) begin
      if (Br_ALU_SIMT && (WarpID_ALU_SIMT == WARP_ID_W'(j))) br_pend_d[j] = 1'b0;
      if (grant_any && grant_branch && (grant_warp == WARP_ID_W'(j))) br_pend_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      br_pend_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      br_pend_q <= br_pend_d;
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_any) issue_cnt_q <= issue_cnt_q + 32'd1;
      if ((|Req_OC_Arb) && !grant_any) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign IssueCnt_Arb = issue_cnt_q;
  assign StallCnt_Arb = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_arb.sv
// Self-checking bench for alu_issue_arb: directed vector table, reset
// sequence, and randomized traffic against a queue/array reference model.
module tb_alu_issue_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] warp;
  logic [3:0]  br;
  logic [3:0]  rw;
  logic        cdb;
  logic        brv;
  logic [2:0]  brw;
  logic [3:0]  grant;
  logic [2:0]  gidx;
  logic        valid;
  logic [7:0]  pend;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_arb #(.NUM_REQ(4), .NUM_WARP(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .Req_OC_Arb         (req),
    .ReqWarpID_OC_Arb   (warp),
    .ReqBranch_OC_Arb   (br),
    .ReqRegWrite_OC_Arb (rw),
    .CdbBusy_Arb        (cdb),
    .Br_ALU_SIMT        (brv),
    .WarpID_ALU_SIMT    (brw),
    .Grant_Arb_OC       (grant),
    .GrantIdx_Arb_OC    (gidx),
    .Valid_OC_ALU       (valid),
    .BrPending_Arb      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] warp;
    logic [3:0]  br;
    logic [3:0]  rw;
    logic        cdb;
    logic        brv;
    logic [2:0]  brw;
    logic [3:0]  eg;
    logic [2:0]  ei;
    logic [7:0]  ep;
  } vec_t;

  vec_t tbl[21];

  // Reference model state: round-robin pointer and pending flag per warp.
  int m_ptr;
  bit m_pend[8];
  int m_gnt_idx;   // -1 when nothing is granted

  function automatic int warp_of(int e);
    return int'(warp[3*e +: 3]);
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int w = 0; w < 8; w++) v[w] = m_pend[w];
    return v;
  endfunction

  function automatic logic [11:0] wp(int w3, int w2, int w1, int w0);
    return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endfunction

  function automatic vec_t mk(logic [3:0] r, logic [11:0] w, logic [3:0] b, logic [3:0] rwv,
                              logic c, logic bv, logic [2:0] bw,
                              logic [3:0] eg, logic [2:0] ei, logic [7:0] ep);
    vec_t v;
    v.req = r; v.warp = w; v.br = b; v.rw = rwv; v.cdb = c;
    v.brv = bv; v.brw = bw; v.eg = eg; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int w = 0; w < 8; w++) m_pend[w] = 1'b0;
  endtask

  task automatic model_eval();
    m_gnt_idx = -1;
    for (int off = 0; off < 4; off++) begin
      int e;
      e = (m_ptr + off) % 4;
      if (m_gnt_idx < 0 && req[e] && !m_pend[warp_of(e)] && !(rw[e] && cdb))
        m_gnt_idx = e;
    end
  endtask

  task automatic model_commit();
    if (brv) m_pend[brw] = 1'b0;
    if (m_gnt_idx >= 0) begin
      if (br[m_gnt_idx]) m_pend[warp_of(m_gnt_idx)] = 1'b1;
      m_ptr = (m_gnt_idx + 1) % 4;
    end
  endtask

  task automatic chk(string nm, logic [3:0] eg, logic [2:0] ei, logic [7:0] ep);
    n_cmp++;
    if (grant !== eg) begin
      n_bad++; $display("FAIL %s grant got %b want %b", nm, grant, eg);
    end
    n_cmp++;
    if (gidx !== ei) begin
      n_bad++; $display("FAIL %s idx got %0d want %0d", nm, gidx, ei);
    end
    n_cmp++;
    if (valid !== (|eg)) begin
      n_bad++; $display("FAIL %s valid got %b want %b", nm, valid, |eg);
    end
    n_cmp++;
    if (pend !== ep) begin
      n_bad++; $display("FAIL %s pend got %h want %h", nm, pend, ep);
    end
  endtask

  // Inputs are already driven; check mid-cycle, then advance the model across the edge.
  task automatic run_cycle(string nm, bit use_model, logic [3:0] eg, logic [2:0] ei, logic [7:0] ep);
    #3;
    model_eval();
    if (use_model) begin
      if (m_gnt_idx >= 0) chk(nm, 4'(1 << m_gnt_idx), 3'(m_gnt_idx), m_pend_vec());
      else chk(nm, 4'b0, 3'd0, m_pend_vec());
    end else begin
      chk(nm, eg, ei, ep);
    end
    @(posedge clk);
    model_commit();
    #2;
  endtask

  task automatic drive(logic [3:0] r, logic [11:0] w, logic [3:0] b, logic [3:0] rwv,
                       logic c, logic bv, logic [2:0] bw);
    req = r; warp = w; br = b; rw = rwv; cdb = c; brv = bv; brw = bw;
  endtask

  initial begin
    // Round-robin sweep.
    for (int i = 0; i < 5; i++)
      tbl[i] = mk(4'hF, 12'h0, 4'h0, 4'h0, 0, 0, 3'd0, 4'(1 << (i % 4)), 3'(i % 4), 8'h00);
    // Branch on warp 5 blocks its sibling until resolved.
    tbl[5]  = mk(4'h6, wp(0,5,5,0), 4'h2, 4'h0, 0, 0, 3'd0, 4'h2, 3'd1, 8'h00);
    tbl[6]  = mk(4'h4, wp(0,5,5,0), 4'h0, 4'h0, 0, 1, 3'd5, 4'h0, 3'd0, 8'h20);
    tbl[7]  = mk(4'h4, wp(0,5,5,0), 4'h0, 4'h0, 0, 0, 3'd0, 4'h4, 3'd2, 8'h00);
    // CDB busy withholds the register writer but not the branch.
    tbl[8]  = mk(4'h9, wp(3,0,0,0), 4'h8, 4'h1, 1, 0, 3'd0, 4'h8, 3'd3, 8'h00);
    tbl[9]  = mk(4'h1, wp(0,0,0,0), 4'h0, 4'h1, 0, 1, 3'd3, 4'h1, 3'd0, 8'h08);
    tbl[10] = mk(4'h1, wp(0,0,0,0), 4'h0, 4'h1, 1, 0, 3'd0, 4'h0, 3'd0, 8'h00);
    tbl[11] = mk(4'h1, wp(0,0,0,0), 4'h0, 4'h1, 0, 0, 3'd0, 4'h1, 3'd0, 8'h00);
    // Same-warp set and clear together: set wins.
    tbl[12] = mk(4'h2, wp(0,0,2,0), 4'h2, 4'h0, 0, 1, 3'd2, 4'h2, 3'd1, 8'h00);
    tbl[13] = mk(4'h4, wp(0,2,0,0), 4'h0, 4'h0, 0, 0, 3'd0, 4'h0, 3'd0, 8'h04);
    tbl[14] = mk(4'h4, wp(0,2,0,0), 4'h0, 4'h0, 0, 1, 3'd2, 4'h0, 3'd0, 8'h04);
    tbl[15] = mk(4'h4, wp(0,2,0,0), 4'h0, 4'h0, 0, 0, 3'd0, 4'h4, 3'd2, 8'h00);
    // Different-warp set and clear both apply; stray resolution ignored.
    tbl[16] = mk(4'h8, wp(1,0,0,0), 4'h8, 4'h0, 0, 0, 3'd0, 4'h8, 3'd3, 8'h00);
    tbl[17] = mk(4'h1, wp(0,0,0,6), 4'h1, 4'h0, 0, 1, 3'd1, 4'h1, 3'd0, 8'h02);
    tbl[18] = mk(4'h0, wp(0,0,0,0), 4'h0, 4'h0, 0, 0, 3'd0, 4'h0, 3'd0, 8'h40);
    tbl[19] = mk(4'h0, wp(0,0,0,0), 4'h0, 4'h0, 0, 1, 3'd6, 4'h0, 3'd0, 8'h40);
    tbl[20] = mk(4'h0, wp(0,0,0,0), 4'h0, 4'h0, 0, 1, 3'd3, 4'h0, 3'd0, 8'h00);

    rst = 1'b0;
    drive(4'hF, 12'h0, 4'h0, 4'h0, 0, 0, 3'd0);
    model_reset();
    #3 chk("reset_state", 4'h0, 3'd0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b1;

    for (int v = 0; v < 21; v++) begin
      drive(tbl[v].req, tbl[v].warp, tbl[v].br, tbl[v].rw, tbl[v].cdb, tbl[v].brv, tbl[v].brw);
      run_cycle($sformatf("vec%0d", v), 1'b0, tbl[v].eg, tbl[v].ei, tbl[v].ep);
    end

    // Fill every warp's pending bit, last grant on entry 1 so the pointer sits at 2.
    for (int k = 0; k < 8; k++) begin
      int e;
      logic [11:0] w;
      e = (k + 2) % 4;
      w = 12'h0;
      w[3*e +: 3] = 3'(k);
      drive(4'(1 << e), w, 4'(1 << e), 4'h0, 0, 0, 3'd0);
      run_cycle($sformatf("fill%0d", k), 1'b1, 4'h0, 3'd0, 8'h00);
    end
    drive(4'h0, 12'h0, 4'h0, 4'h0, 0, 0, 3'd0);
    run_cycle("full_pend", 1'b0, 4'h0, 3'd0, 8'hFF);

    // Asynchronous reset mid-cycle with requests present.
    drive(4'hF, 12'h0, 4'h0, 4'h0, 0, 0, 3'd0);
    #1 rst = 1'b0;
    #1 chk("async_reset", 4'h0, 3'd0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    run_cycle("post_reset", 1'b0, 4'h1, 3'd0, 8'h00);

    // Randomized traffic; an entry holds its request until granted.
    drive(4'h0, 12'h0, 4'h0, 4'h0, 0, 0, 3'd0);
    for (int c = 0; c < 400; c++) begin
      logic [3:0] gmask;
      for (int e = 0; e < 4; e++) begin
        if (!req[e]) begin
          req[e] = ($urandom_range(0, 9) < 6);
          warp[3*e +: 3] = 3'($urandom_range(0, 7));
          br[e] = ($urandom_range(0, 3) == 0);
          rw[e] = !br[e] && ($urandom_range(0, 1) == 1);
        end
      end
      cdb = ($urandom_range(0, 9) < 3);
      brv = ($urandom_range(0, 1) == 1);
      brw = 3'($urandom_range(0, 7));
      run_cycle($sformatf("rand%0d", c), 1'b1, 4'h0, 3'd0, 8'h00);
      gmask = (m_gnt_idx >= 0) ? 4'(1 << m_gnt_idx) : 4'h0;
      req = req & ~gmask;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_arb.md
# alu_issue_arb

Round-robin issue arbiter that shares the single per-SM ALU pipeline between NUM_REQ operand-collector (OC) entries. Each cycle it grants at most one ready OC entry. The parent drives the ALU input bundle from the granted entry's payload. The arbiter keeps a per-warp branch-pending mask so a warp with a BEQ/BLT in flight cannot issue again until SIMT has seen the outcome. It also withholds register-writing ops when the CDB slot is already claimed.

## Interface
- NUM_REQ, 4, number of OC entries competing for the ALU (2..8)
- NUM_WARP, 8, warps tracked by the branch-pending mask
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- Req_OC_Arb  in  NUM_REQ  entry i holds a complete ALU op
- ReqWarpID_OC_Arb  in  3*NUM_REQ  warp ID per entry, flattened, entry i at [3i+2:3i]
- ReqBranch_OC_Arb  in  NUM_REQ  entry i is BEQ/BLT
- ReqRegWrite_OC_Arb  in  NUM_REQ  entry i writes a register through the CDB
- CdbBusy_Arb  in  1  CDB slot for next cycle already taken by another unit
- Br_ALU_SIMT  in  1  ALU branch resolution valid
- WarpID_ALU_SIMT  in  3  warp of resolving branch
- Grant_Arb_OC  out  NUM_REQ  one-hot grant; entry frees on grant
- GrantIdx_Arb_OC  out  3  binary index of granted entry, payload mux select
- Valid_OC_ALU  out  1  an op is issued this cycle; equals |Grant_Arb_OC
- BrPending_Arb  out  NUM_WARP  branch-pending mask, observable for debug/Scb

## Operation
- Eligibility of entry i: Req[i] and !BrPending[warp_i] and !(ReqRegWrite[i] and CdbBusy_Arb).
- Selection: first eligible entry at or after round-robin pointer rr_ptr, searching upward with wrap at NUM_REQ-1 -> 0.
- On a grant of entry g, rr_ptr <= g+1 (wrapping to 0 when g = NUM_REQ-1). With no grant, rr_ptr holds.
- Outputs are combinational from current Req and state. The OC must hold Req and payload stable until granted; dropping Req without a grant is illegal.
- Branch-pending mask:
  - Set bit w when a granted entry has ReqBranch=1 and warp w.
  - Clear bit w when Br_ALU_SIMT=1 with WarpID_ALU_SIMT=w.
  - Set and clear of the same warp in one cycle: set wins. Different warps: both apply.
- Multiple entries from the same warp are legal. After one of them issues a branch, the others are blocked by the mask.
- A branch entry never writes the CDB, so it stays eligible while CdbBusy_Arb=1.
- GrantIdx_Arb_OC is 0 when there is no grant.

## Timing
- Reset values: rr_ptr=0, BrPending=0, Grant=0, GrantIdx=0, Valid_OC_ALU=0. Reset takes effect immediately (asynchronous). An op granted in the same cycle as reset is lost, and the OC is reset with it.
- Grant latency: 0 cycles, same cycle as an eligible Req.
- Branch turnaround: granted at t, ALU registers it at edge t/t+1, Br_ALU_SIMT high during t+1, bit clears at end of t+1. The same warp is eligible again at t+2, so the minimum same-warp issue spacing after a branch is 2 cycles.
- Throughput: one op per cycle when the eligible set is non-empty.
- A Br_ALU_SIMT for a warp with its bit clear is ignored (no error).

## Configuration
- ALU_ARB_PERF_CNT_EN:
  - Defined: adds output IssueCnt_Arb (32b), counting granted cycles.
  - Defined: adds output StallCnt_Arb (32b), counting cycles with |Req=1 and no grant.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Structure
- Shared package holds: WARP_ID_W=3, the NUM_WARP default, and the branch ALUop / flag encodings used by OC and ALU.
- One sub-module, rr_pick: a combinational rotate-priority encoder (request vector + pointer -> one-hot + index). It is reusable by the MEM-unit arbiter.

## Test plan
- All 4 entries request continuously, no branches, CdbBusy=0 -> grants 0,1,2,3,0 on consecutive cycles, Valid_OC_ALU always 1.
- Entry 1 requests a branch for warp 5 at t, entry 2 requests a non-branch for warp 5 -> entry 1 granted at t, BrPending[5]=1, entry 2 blocked at t+1. Br_ALU_SIMT (warp 5) at t+1 -> entry 2 granted at t+2.
- CdbBusy=1, entry 0 RegWrite, entry 3 branch -> only entry 3 granted. Drop CdbBusy -> entry 0 granted next cycle.
- Same-cycle clear of warp 2 and a new branch grant for warp 2 -> BrPending[2] stays 1.
- Reset asserted mid-stream with BrPending=8'hFF, rr_ptr=2 -> all outputs 0 immediately; after release, entry 0 wins first.
- With ALU_ARB_PERF_CNT_EN: 10 cycles of Req=4'b0001, entry 0 of warp 0 branch at cycle 0, resolved at cycle 5 -> IssueCnt and StallCnt match the grant trace cycle-for-cycle (grants at cycles 0 and 6–9 give IssueCnt=5, StallCnt=5).
